param_register_file: RTL
========================

// Module: param_register_file
// PURPOSE
//  Parametrised register file for the pipelined CPU generation: 2 async read ports, 2 write ports (ALU WB, load WB),
//  optional hardwired-zero R0, write-to-read bypass, per-register busy scoreboard for hazard detection.
//  Sits between decode (reads, busy check, busy mark) and writeback (writes, busy clear).
// PARAMETERS
//  DATA_W   16  register width in bits
//  ADDR_W   4   address width; DEPTH = 2**ADDR_W registers
//  ZERO_R0  1   1: register 0 reads 0, ignores writes, never busy
//  BYPASS   1   1: same-cycle write data forwarded to read ports
// PORTS
//  clk            in   1       rising-edge clock
//  rst_n          in   1       asynchronous active-low reset
//  ReadRegister1  in   ADDR_W  read port 1 address
//  ReadRegister2  in   ADDR_W  read port 2 address
//  ReadData1      out  DATA_W  read port 1 data (combinational)
//  ReadData2      out  DATA_W  read port 2 data (combinational)
//  Busy1          out  1       register at ReadRegister1 has a pending producer
//  Busy2          out  1       register at ReadRegister2 has a pending producer
//  WriteEnA       in   1       write port A enable (ALU writeback)
//  WriteRegA      in   ADDR_W  write port A address
//  WriteDataA     in   DATA_W  write port A data
//  WriteEnB       in   1       write port B enable (load writeback)
//  WriteRegB      in   ADDR_W  write port B address
//  WriteDataB     in   DATA_W  write port B data
//  MarkEn         in   1       set busy bit of MarkReg (decode issued a producer)
//  MarkReg        in   ADDR_W  register to mark busy
//  BusyCount      out  ADDR_W+1 number of registers currently busy (registered)
// BEHAVIOUR
//  Reset (rst_n=0, async): all registers <= 0, all busy bits <= 0, BusyCount <= 0; ReadData* = 0, Busy* = 0 while held.
//  Reset mid-operation discards all in-flight writes/marks; first write accepted on first rising edge after rst_n=1.
//  Writes: registered on rising clk; 1-cycle latency to array. WriteEnA and WriteEnB to different addresses both commit.
//  Same-address dual write: port B wins (load is the younger result); port A data dropped.
//  Reads: combinational from array. BYPASS=1: if WriteEn{A,B} active and WriteReg matches ReadRegister, ReadData
//   shows incoming data that cycle (B over A when both match). BYPASS=0: old value until next edge.
//  ZERO_R0=1: address 0 reads 0, writes to 0 ignored (not bypassed), MarkEn on 0 ignored, Busy for 0 always 0.
//  Scoreboard: busy[i] set at edge when MarkEn && MarkReg==i; cleared at edge when any write enable targets i.
//   Simultaneous mark and write to same i: busy stays 1 (mark = new producer wins); write data still committed.
//   Mark on already-busy register: stays 1 (no count). Write to non-busy register: busy stays 0, data committed.
//  Busy1/Busy2: combinational from busy[] (no bypass of same-cycle clear or mark).
//  BusyCount: popcount of busy[] after each edge; range 0..DEPTH (DEPTH-1 when ZERO_R0=1); no wrap.
//  Out-of-range: none possible (DEPTH = 2**ADDR_W). X on addresses not required to be handled.
// TESTING
//  T1 reset: write R3=0x1234, assert rst_n=0 mid-cycle -> ReadData for R3 = 0 immediately, BusyCount=0.
//  T2 bypass: WriteEnA R1=0x000F, ReadRegister1=1 same cycle -> ReadData1=0x000F before edge; with BYPASS=0 -> old 0.
//  T3 dual write collision: A R5=0x1111, B R5=0x2222 same edge -> R5 reads 0x2222; A R6/B R7 distinct -> both commit.
//  T4 R0: write R0=0xFFFF and MarkEn R0 -> ReadData=0, Busy=0, BusyCount unchanged (ZERO_R0=1).
//  T5 scoreboard: mark R2,R4 -> BusyCount=2, Busy1=1 for R2; write B R2 -> Busy clear next edge, BusyCount=1.
//  T6 mark+write same edge R4 -> R4 busy stays 1, data updated; mark all 15 -> BusyCount=15, no wrap.

Source files
------------

// File: rtl/param_register_file.sv
// Parametrised register file: two combinational read ports and two write
// ports. Port B has priority over port A. Optional hardwired-zero R0 and
// optional write-to-read bypass. A per-register busy scoreboard supports
// hazard detection, with a registered count of busy registers.
module param_register_file #(
  parameter int unsigned DATA_W  = 16,
  parameter int unsigned ADDR_W  = 4,
  parameter bit          ZERO_R0 = 1'b1,
  parameter bit          BYPASS  = 1'b1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] ReadRegister1,
  input  logic [ADDR_W-1:0] ReadRegister2,
  output logic [DATA_W-1:0] ReadData1,
  output logic [DATA_W-1:0] ReadData2,
  output logic              Busy1,
  output logic              Busy2,
  input  logic              WriteEnA,
  input  logic [ADDR_W-1:0] WriteRegA,
  input  logic [DATA_W-1:0] WriteDataA,
  input  logic              WriteEnB,
  input  logic [ADDR_W-1:0] WriteRegB,
  input  logic [DATA_W-1:0] WriteDataB,
  input  logic              MarkEn,
  input  logic [ADDR_W-1:0] MarkReg,
  output logic [ADDR_W:0]   BusyCount
);

  localparam int unsigned DEPTH = 2**ADDR_W;
  localparam int unsigned CNT_W = ADDR_W + 1;

  logic [DATA_W-1:0] regs_q [DEPTH];
  logic [DATA_W-1:0] regs_d [DEPTH];
  logic [DEPTH-1:0]  busy_q, busy_d;
  logic [CNT_W-1:0]  count_q, count_d;

  // Read with optional forwarding of same-cycle write data. Port B is applied
  // last so it overrides port A. Forwarding is gated by rst_n, so the reads
  // stay 0 while reset is held.
  function automatic logic [DATA_W-1:0] read_port(input logic [ADDR_W-1:0] addr);
    logic [DATA_W-1:0] v;
    v = regs_q[addr];
    if (BYPASS && rst_n) begin
      if (WriteEnA && (WriteRegA == addr)) v = WriteDataA;
      if (WriteEnB && (WriteRegB == addr)) v = WriteDataB;
    end
    if (ZERO_R0 && (addr == '0)) v = '0;
    return v;
  endfunction

  // Compute next array contents, busy bits and busy population count.
  always_comb begin
    regs_d  = regs_q;
    busy_d  = busy_q;
    count_d = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (WriteEnA && (WriteRegA == ADDR_W'(i))) begin
        regs_d[i] = WriteDataA;
        busy_d[i] = 1'b0;
      end
      if (WriteEnB && (WriteRegB == ADDR_W'(i))) begin
        regs_d[i] = WriteDataB;
        busy_d[i] = 1'b0;
      end
      // A mark on the same edge as a write means a new producer was issued,
      // so the mark wins over the write's clear.
      if (MarkEn && (MarkReg == ADDR_W'(i))) busy_d[i] = 1'b1;
      if (ZERO_R0 && (i == 0)) begin
        regs_d[i] = '0;
        busy_d[i] = 1'b0;
      end
      count_d = count_d + CNT_W'(busy_d[i]);
    end
  end

  // State registers with asynchronous clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < DEPTH; i++) regs_q[i] <= '0;
      busy_q  <= '0;
      count_q <= '0;
    end else begin
      regs_q  <= regs_d;
      busy_q  <= busy_d;
      count_q <= count_d;
    end
  end

  // Combinational read data and busy lookups.
  always_comb begin
    ReadData1 = read_port(ReadRegister1);
    ReadData2 = read_port(ReadRegister2);
    Busy1     = busy_q[ReadRegister1];
    Busy2     = busy_q[ReadRegister2];
    BusyCount = count_q;
  end

endmodule
